// File: rtl/twiddle_pkg.sv
// Shared types and helpers for the twiddle-factor generator and its
// modular arithmetic.
package twiddle_pkg;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  // Default parameter set for the Q=257, 8-point table.
  localparam int Q_DEF       = 257;
  localparam int WIDTH_DEF   = 9;
  localparam int PSI_DEF     = 4;
  localparam int PSI_INV_DEF = 193;

  // Reverse the low 'bits' bits of a; higher bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] a, input int bits);
    logic [31:0] r;
    r = {<<{a}};
    return r >> (32 - bits);
  endfunction

endpackage

// File: rtl/mod_mul.sv
// Combinational a*b mod Q; the full 2*WIDTH-bit product is reduced to [0, Q-1].
module mod_mul #(
  parameter int Q     = 257,
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [2*WIDTH-1:0] prod;

  assign prod = a * b;
  assign y    = WIDTH'(prod % (2*WIDTH)'(Q));

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle-factor generator: builds psi^k and psi^-k mod Q tables on start,
// then serves registered reads in natural or bit-reversed order.
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int Q       = Q_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int N       = 8,
  parameter int LOG_N   = $clog2(N),
  parameter int PSI     = PSI_DEF,
  parameter int PSI_INV = PSI_INV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             ready,
  input  logic             rd_en,
  input  logic [LOG_N-1:0] rd_addr,
  input  logic             rd_bitrev,
  input  logic             rd_inv,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  state_t           state;
  logic [LOG_N-1:0] k;
  logic [WIDTH-1:0] fwd_acc, inv_acc;
  logic [WIDTH-1:0] fwd_nxt, inv_nxt;
  logic [WIDTH-1:0] fwd_wr, inv_wr;
  logic             wr_en;
  logic [LOG_N-1:0] rd_idx;

  logic [WIDTH-1:0] fwd_bank [N];
  logic [WIDTH-1:0] inv_bank [N];

  mod_mul #(.Q(Q), .WIDTH(WIDTH)) u_fwd_mul (
    .a (fwd_acc),
    .b (WIDTH'(PSI)),
    .y (fwd_nxt)
  );

  mod_mul #(.Q(Q), .WIDTH(WIDTH)) u_inv_mul (
    .a (inv_acc),
    .b (WIDTH'(PSI_INV)),
    .y (inv_nxt)
  );

  assign fwd_wr = (k == '0) ? WIDTH'(1) : fwd_nxt;
  assign inv_wr = (k == '0) ? WIDTH'(1) : inv_nxt;
  assign wr_en  = (state == GEN) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= GEN;
            k     <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
        GEN: begin
          // start is deliberately not looked at here: generation runs to completion.
          fwd_acc <= fwd_wr;
          inv_acc <= inv_wr;
          k       <= k + 1'b1;
          if (k == LOG_N'(N-1)) begin
            state <= DONE;
            k     <= '0;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Table storage is left unreset; ready masks stale or partial contents.
  for (genvar i = 0; i < N; i++) begin : g_bank
    always_ff @(posedge clk) begin
      if (wr_en && (k == LOG_N'(i))) begin
        fwd_bank[i] <= fwd_wr;
        inv_bank[i] <= inv_wr;
      end
    end
  end

  assign rd_idx = rd_bitrev ? LOG_N'(bitrev(32'(rd_addr), LOG_N)) : rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en && ready;
      if (rd_en && ready)
        rd_data <= rd_inv ? inv_bank[rd_idx] : fwd_bank[rd_idx];
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Scoreboard bench for twiddle_gen (Q=257, PSI=4, N=8): reads push expected
// data, a negedge monitor pops and compares whenever rd_valid is high.
module tb_twiddle_gen;

  logic       clk = 1'b0;
  logic       rst, start, busy, ready;
  logic       rd_en, rd_bitrev, rd_inv, rd_valid;
  logic [2:0] rd_addr;
  logic [8:0] rd_data;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int last_exp = 0;

  int FWD [8] = '{1, 4, 16, 64, 256, 253, 241, 193};
  int INV [8] = '{1, 193, 241, 253, 256, 64, 16, 4};
  int BRF [8] = '{1, 256, 16, 241, 4, 253, 64, 193};

  twiddle_gen #(.Q(257), .WIDTH(9), .N(8), .LOG_N(3), .PSI(4), .PSI_INV(193)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .ready     (ready),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_bitrev (rd_bitrev),
    .rd_inv    (rd_inv),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every valid output must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rd_valid actual=%0d required=none", rd_data);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(rd_data) != e) begin
          failures++;
          $display("FAIL rd_data actual=%0d required=%0d", rd_data, e);
        end
      end
    end
  end

  task automatic issue(input int addr, input bit br, input bit inv, input int exp);
    rd_en = 1'b1; rd_addr = 3'(addr); rd_bitrev = br; rd_inv = inv;
    exp_q.push_back(exp);
    last_exp = exp;
    tick();
  endtask

  task automatic idle_rd();
    rd_en = 1'b0; rd_bitrev = 1'b0; rd_inv = 1'b0;
  endtask

  // Start generation; optionally read in the start cycle (collision) and
  // poke start plus a not-ready read at a given cycle during GEN.
  task automatic run_gen(input bit coll, input int poke, output int bcyc, output int lat);
    start = 1'b1;
    if (coll) begin
      rd_en = 1'b1; rd_addr = 3'd2; rd_bitrev = 1'b0; rd_inv = 1'b0;
      exp_q.push_back(16);
      last_exp = 16;
    end
    tick();
    start = 1'b0; idle_rd();
    lat = 1; bcyc = 0;
    chk("busy_after_start", int'(busy), 1);
    chk("ready_after_start", int'(ready), 0);
    while (ready !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcyc++;
      start = (lat == poke);
      rd_en = (lat == poke); rd_addr = 3'd5;
      tick();
      lat++;
      if (lat == poke + 1) begin
        chk("rd_valid_not_ready", int'(rd_valid), 0);
        chk("rd_data_held", int'(rd_data), last_exp);
      end
    end
    start = 1'b0; idle_rd();
    if (lat >= 40) chk("gen_timeout", lat, 9);
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) issue(i, 1'b0, 1'b0, FWD[i]);
    for (int i = 0; i < 8; i++) issue(i, 1'b0, 1'b1, INV[i]);
    idle_rd();
    tick();
  endtask

  initial begin
    int bc, lt;
    rst = 1'b1; start = 1'b0; rd_addr = '0;
    idle_rd();
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);

    // Read while IDLE is ignored
    rd_en = 1'b1; rd_addr = 3'd3;
    tick();
    idle_rd();
    chk("idle_rd_valid", int'(rd_valid), 0);
    chk("idle_rd_data", int'(rd_data), 0);

    run_gen(1'b0, -10, bc, lt);
    chk("busy_cycles", bc, 8);
    chk("ready_latency", lt, 9);
    chk("busy_done", int'(busy), 0);

    // Natural reads with single-cycle latency
    issue(7, 1'b0, 1'b0, 193);
    issue(1, 1'b0, 1'b1, 193);
    issue(4, 1'b0, 1'b1, 256);
    idle_rd();
    chk("lat_valid", int'(rd_valid), 1);
    chk("lat_data", int'(rd_data), 256);
    tick();
    chk("valid_drop", int'(rd_valid), 0);
    read_all();

    // Bit-reversed burst, rd_valid must stay high throughout
    for (int i = 0; i < 8; i++) begin
      issue(i, 1'b1, 1'b0, BRF[i]);
      chk("burst_valid", int'(rd_valid), 1);
    end
    idle_rd();
    tick();
    chk("burst_valid_drop", int'(rd_valid), 0);

    // Restart from DONE with same-cycle read, plus start/read pokes during GEN
    run_gen(1'b1, 3, bc, lt);
    chk("restart_busy_cycles", bc, 8);
    chk("restart_ready_latency", lt, 9);
    read_all();

    // Reset at k=3 together with start: reset wins
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mid_gen_busy", int'(busy), 1);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    last_exp = 0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(ready), 0);
    chk("midrst_rd_valid", int'(rd_valid), 0);
    tick();
    chk("midrst_start_dropped", int'(busy), 0);
    chk("midrst_still_not_ready", int'(ready), 0);

    run_gen(1'b0, -10, bc, lt);
    chk("regen_busy_cycles", bc, 8);
    chk("regen_ready_latency", lt, 9);
    read_all();
    for (int i = 0; i < 8; i++) issue(i, 1'b1, 1'b0, BRF[i]);
    idle_rd();
    tick(); tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
